// File: rtl/video_fetch_seq_if.sv
// ----------------------------------------------------------------------------
// video_fetch_seq_if
// Bundle of the signals the fetch/timing sequencer drives toward the video RAM
// port and the bitmap/attribute/shift/mux datapath.
//
// Handshake: vreq is a plain request qualifier with no back-pressure. While
// vreq is high, vaddr is a valid RAM offset. The RAM data for that address is
// captured on the ld_pix / ld_attr strobe, which occurs on the second cycle of
// each two-cycle request.
//
//   vreq     video RAM read request, vaddr valid while high
//   vaddr    13-bit video RAM offset (bitmap or attribute)
//   ld_pix   bitmap byte latch strobe
//   ld_attr  attribute byte latch strobe
//   ld_shift shift-register parallel load + attribute transfer
//   border   1 = border colour, 0 = pixel/attribute path
//   bl       blanking, active-high
//   sync_n   composite sync, active-low
//   int_n    CPU frame interrupt, active-low
//   flasher  flash phase toggle
// ----------------------------------------------------------------------------
interface video_fetch_seq_if;
    logic        vreq;
    logic [12:0] vaddr;
    logic        ld_pix;
    logic        ld_attr;
    logic        ld_shift;
    logic        border;
    logic        bl;
    logic        sync_n;
    logic        int_n;
    logic        flasher;

    modport master (
        output vreq, vaddr, ld_pix, ld_attr, ld_shift,
               border, bl, sync_n, int_n, flasher
    );

    modport slave (
        input  vreq, vaddr, ld_pix, ld_attr, ld_shift,
               border, bl, sync_n, int_n, flasher
    );
endinterface

// File: rtl/video_fetch_seq.sv
// ----------------------------------------------------------------------------
// video_fetch_seq
// Pixel-clock timing and fetch sequencer for the bitmap/attribute video
// datapath: line/frame counters, video RAM addressing, latch/load strobes,
// border select, blanking, composite sync, frame interrupt and flash phase.
//
// Ports:
//   clk  pixel clock, one cycle per displayed pixel, rising edge
//   rst  synchronous reset, active-high
//   vid  master modport of video_fetch_seq_if (all outputs registered)
//
// Timing model: hc/vc name the beam position whose outputs are currently on
// the pins. Every output register is loaded from the decode of the position
// being entered (hc_n/vc_n), so outputs and counters change on the same edge.
// Reset holds a "not yet started" state showing reset values; the first edge
// without reset enters position (0,0) rather than (1,0).
// ----------------------------------------------------------------------------
module video_fetch_seq #(
    parameter int H_TOTAL   = 448,
    parameter int V_TOTAL   = 320,
    parameter int H_BLANK_S = 320,
    parameter int H_BLANK_E = 384,
    parameter int H_SYNC_S  = 336,
    parameter int H_SYNC_E  = 368,
    parameter int V_BLANK_S = 240,
    parameter int V_BLANK_E = 272,
    parameter int V_SYNC_S  = 240,
    parameter int V_SYNC_E  = 256,
    parameter int INT_LINE  = 239,
    parameter int INT_LEN   = 64,
    parameter int FLASH_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    video_fetch_seq_if.master vid
);

    localparam logic [8:0] HC_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] VC_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] HBS     = 9'(H_BLANK_S);
    localparam logic [8:0] HBE     = 9'(H_BLANK_E);
    localparam logic [8:0] HSS     = 9'(H_SYNC_S);
    localparam logic [8:0] HSE     = 9'(H_SYNC_E);
    localparam logic [8:0] VBS     = 9'(V_BLANK_S);
    localparam logic [8:0] VBE     = 9'(V_BLANK_E);
    localparam logic [8:0] VSS     = 9'(V_SYNC_S);
    localparam logic [8:0] VSE     = 9'(V_SYNC_E);
    localparam logic [8:0] INT_V   = 9'(INT_LINE);
    localparam logic [9:0] INT_REM = 10'(INT_LEN - 1);
    localparam logic [7:0] FR_LAST = 8'(FLASH_DIV - 1);

    // Position state
    logic [8:0] hc;
    logic [8:0] vc;
    logic       run;
    logic [7:0] frame_cnt;
    logic [9:0] int_rem;

    // Output registers
    logic        vreq_q;
    logic [12:0] vaddr_q;
    logic        ld_pix_q;
    logic        ld_attr_q;
    logic        ld_shift_q;
    logic        border_q;
    logic        bl_q;
    logic        sync_n_q;
    logic        int_n_q;
    logic        flasher_q;

    // Next position and its decode
    logic [8:0]  hc_n;
    logic [8:0]  vc_n;
    logic        frame_wrap;
    logic        in_fetch;
    logic [2:0]  ph;
    logic [4:0]  col;
    logic [12:0] bitmap_addr;
    logic [12:0] attr_addr;
    logic        fetch_req;
    logic        h_blank;
    logic        v_blank;
    logic        h_sync;
    logic        v_sync;
    logic        int_start;
    logic        disp_area;

    always_comb begin
        hc_n       = hc;
        vc_n       = vc;
        frame_wrap = 1'b0;
        if (run) begin
            if (hc == HC_LAST) begin
                hc_n = '0;
                if (vc == VC_LAST) begin
                    vc_n       = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vc_n = vc + 9'd1;
                end
            end else begin
                hc_n = hc + 9'd1;
            end
        end
    end

    always_comb begin
        in_fetch    = (vc_n < 9'd192) && (hc_n < 9'd256);
        ph          = hc_n[2:0];
        col         = hc_n[7:3];
        // Bitmap rows are interleaved: third, character row within third, pixel row.
        bitmap_addr = {vc_n[7:6], vc_n[2:0], vc_n[5:3], col};
        attr_addr   = {3'b110, vc_n[7:3], col};
        fetch_req   = in_fetch && !ph[2];
        h_blank     = (hc_n >= HBS) && (hc_n < HBE);
        v_blank     = (vc_n >= VBS) && (vc_n < VBE);
        h_sync      = (hc_n >= HSS) && (hc_n < HSE);
        v_sync      = (vc_n >= VSS) && (vc_n < VSE);
        int_start   = (vc_n == INT_V) && (hc_n == HBS);
        // Pixels leave the shifter one cell after fetch, hence the 8..263 span.
        disp_area   = (vc_n < 9'd192) && (hc_n >= 9'd8) && (hc_n <= 9'd263);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc         <= '0;
            vc         <= '0;
            run        <= 1'b0;
            frame_cnt  <= '0;
            int_rem    <= '0;
            vreq_q     <= 1'b0;
            vaddr_q    <= '0;
            ld_pix_q   <= 1'b0;
            ld_attr_q  <= 1'b0;
            ld_shift_q <= 1'b0;
            border_q   <= 1'b1;
            bl_q       <= 1'b1;
            sync_n_q   <= 1'b1;
            int_n_q    <= 1'b1;
            flasher_q  <= 1'b0;
        end else begin
            run        <= 1'b1;
            hc         <= hc_n;
            vc         <= vc_n;
            vreq_q     <= fetch_req;
            // Address holds its last value outside request cycles.
            if (fetch_req) begin
                vaddr_q <= ph[1] ? attr_addr : bitmap_addr;
            end
            ld_pix_q   <= in_fetch && (ph == 3'd1);
            ld_attr_q  <= in_fetch && (ph == 3'd3);
            ld_shift_q <= in_fetch && (ph == 3'd7);
            border_q   <= !disp_area;
            bl_q       <= h_blank || v_blank;
            sync_n_q   <= !(h_sync || v_sync);

            // Interrupt length is counted in cycles so it can run across the line wrap.
            if (int_start) begin
                int_n_q <= 1'b0;
                int_rem <= INT_REM;
            end else if (int_rem != '0) begin
                int_n_q <= 1'b0;
                int_rem <= int_rem - 10'd1;
            end else begin
                int_n_q <= 1'b1;
            end

            if (frame_wrap) begin
                if (frame_cnt == FR_LAST) begin
                    frame_cnt <= '0;
                    flasher_q <= !flasher_q;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    assign vid.vreq     = vreq_q;
    assign vid.vaddr    = vaddr_q;
    assign vid.ld_pix   = ld_pix_q;
    assign vid.ld_attr  = ld_attr_q;
    assign vid.ld_shift = ld_shift_q;
    assign vid.border   = border_q;
    assign vid.bl       = bl_q;
    assign vid.sync_n   = sync_n_q;
    assign vid.int_n    = int_n_q;
    assign vid.flasher  = flasher_q;

endmodule

// File: tb/tb_video_fetch_seq.sv
// ----------------------------------------------------------------------------
// tb_video_fetch_seq
// Bench for video_fetch_seq using a shortened raster (the fetch window and
// address map are unchanged) so a full frame plus a reset restart fit in a
// short run. The interrupt window is placed to straddle a line wrap and the
// flash divider is 1 so FLASHER toggles at the first frame boundary.
// A position-based model derives every output from the cycle index since
// reset release; literal checks pin the model at chosen positions.
// ----------------------------------------------------------------------------
module tb_video_fetch_seq;

    localparam int HT     = 272;
    localparam int VT     = 196;
    localparam int HBS    = 264;
    localparam int HBE    = 270;
    localparam int HSS    = 266;
    localparam int HSE    = 268;
    localparam int VBS    = 192;
    localparam int VBE    = 195;
    localparam int VSS    = 193;
    localparam int VSE    = 194;
    localparam int INTL   = 191;
    localparam int INTLEN = 16;
    localparam int FDIV   = 1;
    localparam int FL     = HT * VT;          // 53312
    localparam int INT_T  = INTL * HT + HBS;  // 52216
    localparam int RST_T  = FL + 2 * HT + 5;  // vc=2, hc=5 of second frame

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t = -1;
    bit   started = 1'b0;
    int   checks = 0;
    int   failures = 0;

    video_fetch_seq_if vif();

    video_fetch_seq #(
        .H_TOTAL(HT), .V_TOTAL(VT),
        .H_BLANK_S(HBS), .H_BLANK_E(HBE),
        .H_SYNC_S(HSS), .H_SYNC_E(HSE),
        .V_BLANK_S(VBS), .V_BLANK_E(VBE),
        .V_SYNC_S(VSS), .V_SYNC_E(VSE),
        .INT_LINE(INTL), .INT_LEN(INTLEN), .FLASH_DIV(FDIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vif)
    );

    // clock / reset-relative cycle index
    always #5 clk = ~clk;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) t <= -1;
        else     t <= t + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, act, exp);
        end
    endtask

    // scoreboard: model + per-cycle compare
    logic [12:0] exp_vaddr = '0;
    logic        prev_int_n = 1'b1;
    logic        prev_flash = 1'b0;
    bit          seen_int = 1'b0;
    bit          seen_flash = 1'b0;
    int          int_low_cnt = 0;
    bit          int_len_done = 1'b0;

    always @(negedge clk) begin
        if (started) begin
            int h, v, f;
            logic e_fetch, e_vreq, e_pix, e_attr, e_shift, e_border, e_bl, e_sync_n, e_int_n, e_flash;
            if (t < 0) begin
                exp_vaddr = '0;
                e_vreq = 0; e_pix = 0; e_attr = 0; e_shift = 0;
                e_border = 1; e_bl = 1; e_sync_n = 1; e_int_n = 1; e_flash = 0;
            end else begin
                h = t % HT;
                v = (t / HT) % VT;
                f = t / FL;
                e_fetch = (v < 192) && (h < 256);
                e_vreq  = e_fetch && (h % 8 < 4);
                e_pix   = e_fetch && (h % 8 == 1);
                e_attr  = e_fetch && (h % 8 == 3);
                e_shift = e_fetch && (h % 8 == 7);
                if (e_vreq) begin
                    if (h % 8 < 2)
                        exp_vaddr = 13'(((v / 64) << 11) | ((v % 8) << 8) | (((v / 8) % 8) << 5) | (h / 8));
                    else
                        exp_vaddr = 13'(32'h1800 + ((v / 8) << 5) + (h / 8));
                end
                e_border = !((v < 192) && (h >= 8) && (h <= 263));
                e_bl     = ((h >= HBS) && (h < HBE)) || ((v >= VBS) && (v < VBE));
                e_sync_n = !(((h >= HSS) && (h < HSE)) || ((v >= VSS) && (v < VSE)));
                e_int_n  = !((t >= INT_T) && (((t - INT_T) % FL) < INTLEN));
                e_flash  = ((f / FDIV) % 2) == 1;
            end

            chk("vreq",     16'(vif.vreq),     16'(e_vreq));
            chk("vaddr",    16'(vif.vaddr),    16'(exp_vaddr));
            chk("ld_pix",   16'(vif.ld_pix),   16'(e_pix));
            chk("ld_attr",  16'(vif.ld_attr),  16'(e_attr));
            chk("ld_shift", 16'(vif.ld_shift), 16'(e_shift));
            chk("border",   16'(vif.border),   16'(e_border));
            chk("bl",       16'(vif.bl),       16'(e_bl));
            chk("sync_n",   16'(vif.sync_n),   16'(e_sync_n));
            chk("int_n",    16'(vif.int_n),    16'(e_int_n));
            chk("flasher",  16'(vif.flasher),  16'(e_flash));

            // hand-computed literal expectations
            if (t == 0) begin
                chk("lit_t0_vreq",  16'(vif.vreq), 16'h1);
                chk("lit_t0_vaddr", 16'(vif.vaddr), 16'h0000);
            end
            if (t == 2)              chk("lit_attr0_vaddr", 16'(vif.vaddr), 16'h1800);
            if (t == 77 * HT + 40)   chk("lit_bitmap_4d_5", 16'(vif.vaddr), 16'h0D25);
            if (t == 77 * HT + 42)   chk("lit_attr_4d_5",   16'(vif.vaddr), 16'h1925);
            if (t == 191 * HT + 263) chk("lit_border_263",  16'(vif.border), 16'h0);
            if (t == 191 * HT + 264) chk("lit_border_264",  16'(vif.border), 16'h1);

            if (t >= 0 && prev_int_n && !vif.int_n && !seen_int) begin
                seen_int = 1'b1;
                chk("lit_int_fall_t", 16'(t), 16'(52216));
            end
            if (!vif.int_n) int_low_cnt++;
            if (t >= 0 && !prev_int_n && vif.int_n && !int_len_done) begin
                int_len_done = 1'b1;
                chk("lit_int_len", 16'(int_low_cnt), 16'(16));
            end
            if (t >= 0 && (vif.flasher !== prev_flash) && !seen_flash) begin
                seen_flash = 1'b1;
                chk("lit_flash_toggle_t", 16'(t), 16'(53312));
            end
            prev_int_n = vif.int_n;
            prev_flash = vif.flasher;
        end
    end

    // driver
    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        while (t != RST_T && n < 60000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_reset_point", 16'(t), 16'(RST_T));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (600) @(posedge clk);
        #1;

        chk("seen_int_event",   16'(seen_int),     16'h1);
        chk("seen_int_release", 16'(int_len_done), 16'h1);
        chk("seen_flash_event", 16'(seen_flash),   16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
